nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nsa_pkg.sv | 17 +
 rtl/cla_4bit.sv | 29 ++
 rtl/nibble_serial_adder.sv | 149 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must index WIDTH/NIB_W nibbles; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width / NIB_W > 1) ? $clog2(width / NIB_W) : 1;
  endfunction

endpackage

// File: rtl/cla_4bit.sv
// Single 4-bit carry-lookahead adder slice used once per nibble step.
module cla_4bit
  import nsa_pkg::*;
(
  output logic             cout,
  output logic [NIB_W-1:0] s,
  input  logic             cin,
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[NIB_W-1:0];
    cout = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per clock through a shared CLA slice.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [NIB_W-1:0] slice_s;
  logic             slice_c;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  cla_4bit u_slice (
    .cout (slice_c),
    .s    (slice_s),
    .cin  (carry_q),
    .a    (a_q[NIB_W-1:0]),
    .b    (b_q[NIB_W-1:0])
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_d     = a_q >> NIB_W;
        b_d     = b_q >> NIB_W;
        carry_d = slice_c;
        acc_d   = {slice_s, acc_q[WIDTH-1:NIB_W]};
        // Result registers change only when the final nibble lands.
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = {slice_s, acc_q[WIDTH-1:NIB_W]};
          cout_d  = slice_c;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_d   = (a_msb_q == b_msb_q) && (slice_s[NIB_W-1] != a_msb_q);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): vector table plus
// scoreboard, with hand-written sequences for handshake, hold and reset cases.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   accept_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t       e;
    logic [W:0] t;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: push on accept, pop and compare on result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, cin));
        accept_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_sum", sum, e.sum);
          checkOutput("sb_cout", cout, e.cout);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          checkOutput("sb_ovf", ovf, e.ovf);
`endif
        end
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    bit ok;
    @(posedge clk);
    #1;
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drain", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    exp_t e;
    int   viol;
    int   base;
    logic [W-1:0] ra, rb;
    logic         rc;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    // Reset state
    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    checkOutput("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: out_valid rises on the 4th edge after accept
    out_ready = 1'b0;
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    checkOutput("lat_busy", busy, 1);
    checkOutput("lat_edge0", out_valid, 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("lat_edge%0d", k), out_valid, (k == 4) ? 1 : 0);
    end
    checkOutput("lat_sum", sum, 16'h5555);
    out_ready = 1'b1;
    waitDrain();

    // Vector table
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
      waitDrain();
      checkOutput($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
      checkOutput($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
`endif
    end

    // Random operands against the scoreboard model
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc);
      waitDrain();
    end

    // Hold in DONE with out_ready low and in_valid high
    out_ready = 1'b0;
    e = model(16'h0BAD, 16'h1111, 1'b0);
    applyStimulus(16'h0BAD, 16'h1111, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    checkOutput("hold_reached_done", out_valid, 1);
    @(posedge clk);
    #1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    in_valid = 1'b1;
    base = accept_cyc.size();
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sum !== e.sum || cout !== e.cout || in_ready !== 1'b0 || out_valid !== 1'b1) viol++;
    end
    checkOutput("hold_stable", viol, 0);
    checkOutput("hold_no_accept", accept_cyc.size() - base, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_hs_in_ready", in_ready, 1);
    checkOutput("post_hs_out_valid", out_valid, 0);
    checkOutput("idle_sum_hold", sum, e.sum);
    checkOutput("hold_sb_empty", sb.size(), 0);

    // Back-to-back with in_valid held high
    base = accept_cyc.size();
    a = 16'h0001; b = 16'h0002; cin = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      viol = 1;
      for (int i = 0; i < 20 && viol != 0; i++) begin
        @(negedge clk);
        if (in_ready) viol = 0;
      end
      checkOutput($sformatf("b2b_accept%0d", k), viol, 0);
      @(posedge clk);
      #1;
      if (k < 3) begin
        a = W'(16'h1111 * (k + 2));
        b = W'(16'h0F0F + k);
        cin = 1'(k);
      end else begin
        in_valid = 1'b0;
      end
    end
    waitDrain();
    checkOutput("b2b_count", accept_cyc.size() - base, 4);
    for (int k = 1; k < 4; k++) begin
      if (accept_cyc.size() > base + k)
        checkOutput($sformatf("b2b_spacing%0d", k),
                    accept_cyc[base + k] - accept_cyc[base + k - 1], 6);
    end

    // Reset on the 2nd RUN edge aborts the operation
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("abort_busy", busy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_busy_low", busy, 0);
    checkOutput("abort_sum", sum, 0);
    checkOutput("abort_cout", cout, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) viol++;
    end
    checkOutput("abort_no_result", viol, 0);
    applyStimulus(16'h0FF0, 16'h0F0F, 1'b1);
    waitDrain();
    checkOutput("after_abort_sum", sum, 16'h1F00);
    checkOutput("after_abort_cout", cout, 0);

    checkOutput("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
